// File: rtl/ddu_pkg.sv
// Shared types and constants for the debug/display controller: run-state
// encoding, display-source select codes and the hex-to-7-segment table.
package ddu_pkg;

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2
  } run_state_e;

  localparam logic [1:0] SEL_MEM  = 2'd0;
  localparam logic [1:0] SEL_REG  = 2'd1;
  localparam logic [1:0] SEL_PC   = 2'd2;
  localparam logic [1:0] SEL_ADDR = 2'd3;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/ddu_if.sv
// CPU-side bundle of the debug controller. With DDU_BREAKPOINT_EN defined it
// also carries the breakpoint address and valid flag.
interface ddu_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DIGITS = 8
);
  logic                  instr_done;
  logic [31:0]           pc;
  logic [4*DIGITS-1:0]   mem_data;
  logic [4*DIGITS-1:0]   reg_data;
  logic                  run;
  logic [ADDR_W-1:0]     addr;
`ifdef DDU_BREAKPOINT_EN
  logic [31:0]           bp_addr;
  logic                  bp_valid;

  modport master (
    input  instr_done, pc, mem_data, reg_data, bp_addr, bp_valid,
    output run, addr
  );
  modport slave (
    output instr_done, pc, mem_data, reg_data, bp_addr, bp_valid,
    input  run, addr
  );
`else
  modport master (
    input  instr_done, pc, mem_data, reg_data,
    output run, addr
  );
  modport slave (
    output instr_done, pc, mem_data, reg_data,
    input  run, addr
  );
`endif
endinterface

// File: rtl/ddu_btn_debounce.sv
// Two-flop synchroniser followed by a debouncer; the level is accepted after
// DEBOUNCE_CYC equal samples and a one-cycle pulse marks its rising edge.
module ddu_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/ddu_debug_ctrl.sv
// Debug/display controller: run/step FSM, inspect-address counter, status
// LEDs and scanned hex display. Optional breakpoint halt: DDU_BREAKPOINT_EN.
module ddu_debug_ctrl
  import ddu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned SCAN_DIV     = 100000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cont_i,
  input  logic              step_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic [1:0]        sel_i,
  ddu_if.master             cpu_if,
  output logic [15:0]       led_o,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o
);

  localparam int unsigned DW    = 4 * DIGITS;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DigW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [ADDR_W-1:0] RegMask = ADDR_W'(31);

  // Button conditioning: index 0 cont, 1 step, 2 inc, 3 dec.
  logic [3:0] btn_raw, btn_level, btn_pulse;
  assign btn_raw = {dec_i, inc_i, step_i, cont_i};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    ddu_btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .btn_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .pulse_o(btn_pulse[i])
    );
  end

  logic cont_lvl, step_p, inc_p, dec_p;
  assign cont_lvl = btn_level[0];
  assign step_p   = btn_pulse[1];
  assign inc_p    = btn_pulse[2];
  assign dec_p    = btn_pulse[3];

  logic unused_btn;
  assign unused_btn = ^{btn_level[3:1], btn_pulse[0]};

  // Run FSM
  run_state_e state_q, state_d;
  logic       cont_ok;
  logic       bp_halt;

`ifdef DDU_BREAKPOINT_EN
  logic bp_halt_q, bp_halt_d, bp_hit;
  assign bp_hit  = cpu_if.instr_done & cpu_if.bp_valid & (cpu_if.pc == cpu_if.bp_addr);
  // After a breakpoint, cont must drop before it can restart the CPU.
  assign cont_ok = cont_lvl & ~bp_halt_q;
  assign bp_halt = bp_halt_q & (state_q == StHalt);
`else
  assign cont_ok = cont_lvl;
  assign bp_halt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
`ifdef DDU_BREAKPOINT_EN
    bp_halt_d = cont_lvl ? bp_halt_q : 1'b0;
`endif
    unique case (state_q)
      StHalt: begin
        if (cont_ok)     state_d = StRun;
        else if (step_p) state_d = StStep;
      end
      StRun: begin
        if (!cont_lvl) begin
          state_d = StHalt;
`ifdef DDU_BREAKPOINT_EN
        end else if (bp_hit) begin
          state_d   = StHalt;
          bp_halt_d = 1'b1;
`endif
        end
      end
      StStep: begin
        if (cont_ok)                state_d = StRun;
        else if (cpu_if.instr_done) state_d = StHalt;
      end
      default: state_d = StHalt;
    endcase
  end

  // Address counter; in register view it is held to 5 bits.
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (inc_p && !dec_p)      addr_d = addr_q + 1'b1;
    else if (dec_p && !inc_p) addr_d = addr_q - 1'b1;
    if (sel_i == SEL_REG)     addr_d = addr_d & RegMask;
  end

  // LEDs
  logic [15:0] led_q, led_d;

  always_comb begin
    led_d[15:8] = cpu_if.pc[7:0];
    led_d[7:0]  = (sel_i == SEL_REG) ? 8'(addr_q[4:0]) : 8'(addr_q);
    if (bp_halt) led_d[15] = 1'b1;
  end

  // Display source and scanner
  logic [DW-1:0]     src, disp_q, disp_d;
  logic [ScanW-1:0]  scan_q, scan_d;
  logic [DigW-1:0]   digit_q, digit_d;
  logic [3:0]        nibble;

  always_comb begin
    unique case (sel_i)
      SEL_MEM:  src = cpu_if.mem_data;
      SEL_REG:  src = cpu_if.reg_data;
      SEL_PC:   src = DW'(cpu_if.pc);
      SEL_ADDR: src = DW'(addr_q);
      default:  src = cpu_if.mem_data;
    endcase
  end

  always_comb begin
    scan_d  = scan_q + 1'b1;
    digit_d = digit_q;
    disp_d  = disp_q;
    if (scan_q == ScanW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      if (digit_q == DigW'(DIGITS - 1)) begin
        // Frame boundary: capture a fresh value so a frame never tears.
        digit_d = '0;
        disp_d  = src;
      end else begin
        digit_d = digit_q + 1'b1;
      end
    end
  end

  assign nibble = 4'(disp_q >> {digit_q, 2'b00});

  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StHalt;
      addr_q  <= '0;
      led_q   <= '0;
      scan_q  <= '0;
      digit_q <= '0;
      disp_q  <= '0;
      an_q    <= '1;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      led_q   <= led_d;
      scan_q  <= scan_d;
      digit_q <= digit_d;
      disp_q  <= disp_d;
      an_q    <= ~(DIGITS'(1) << digit_q);
      seg_q   <= SEG_TABLE[nibble];
    end
  end

`ifdef DDU_BREAKPOINT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bp_halt_q <= 1'b0;
    else         bp_halt_q <= bp_halt_d;
  end
`endif

  assign cpu_if.run  = (state_q != StHalt);
  assign cpu_if.addr = addr_q;
  assign led_o       = led_q;
  assign an_o        = an_q;
  assign seg_o       = seg_q;

endmodule

// File: tb/tb_ddu_debug_ctrl.sv
// Directed bench for ddu_debug_ctrl with short debounce/scan periods.
module tb_ddu_debug_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cont_i, step_i, inc_i, dec_i;
  logic [1:0] sel_i;
  logic [15:0] led_o;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;

  int tests = 0;
  int fails = 0;

  ddu_if #(.ADDR_W(8), .DIGITS(8)) cpu_if ();

  ddu_debug_ctrl #(
    .ADDR_W      (8),
    .DIGITS      (8),
    .DEBOUNCE_CYC(4),
    .SCAN_DIV    (2)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .cont_i(cont_i),
    .step_i(step_i),
    .inc_i (inc_i),
    .dec_i (dec_i),
    .sel_i (sel_i),
    .cpu_if(cpu_if),
    .led_o (led_o),
    .an_o  (an_o),
    .seg_o (seg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // b: 1 step, 2 inc, 3 dec
  task automatic press(input int b);
    if (b == 1) step_i = 1'b1;
    if (b == 2) inc_i = 1'b1;
    if (b == 3) dec_i = 1'b1;
    tick(8);
    step_i = 1'b0;
    inc_i  = 1'b0;
    dec_i  = 1'b0;
    tick(8);
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Align to the start of a new frame, then walk the first n digits.
  task automatic check_frame(input string tag, input logic [31:0] val, input int n);
    int guard = 0;
    logic [7:0] an_exp;
    logic [3:0] nib;
    while (an_o !== 8'h7F && guard < 64) begin tick(1); guard++; end
    while (an_o === 8'h7F && guard < 64) begin tick(1); guard++; end
    check({tag, "_sync"}, 32'(guard < 64), 32'd1);
    for (int i = 0; i < n; i++) begin
      an_exp = ~(8'h01 << i);
      nib    = 4'(val >> (4 * i));
      check({tag, "_an"}, 32'(an_o), 32'(an_exp));
      check({tag, "_seg"}, 32'(seg_o), 32'(hex_seg(nib)));
      tick(2);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    cont_i = 1'b0; step_i = 1'b0; inc_i = 1'b0; dec_i = 1'b0;
    sel_i  = 2'd0;
    cpu_if.instr_done = 1'b0;
    cpu_if.pc         = 32'h0000_00A5;
    cpu_if.mem_data   = 32'h1234_ABCD;
    cpu_if.reg_data   = 32'h0;
`ifdef DDU_BREAKPOINT_EN
    cpu_if.bp_addr  = 32'h0;
    cpu_if.bp_valid = 1'b0;
`endif
    tick(3);
    check("rst_run", 32'(cpu_if.run), 32'd0);
    check("rst_addr", 32'(cpu_if.addr), 32'd0);
    check("rst_led", 32'(led_o), 32'd0);
    check("rst_an", 32'(an_o), 32'hFF);
    check("rst_seg", 32'(seg_o), 32'h7F);
    rst_ni = 1'b1;
    tick(2);

    // Single step: run rises 7 edges after press, falls on instr_done
    step_i = 1'b1;
    tick(6);
    check("step1_pre", 32'(cpu_if.run), 32'd0);
    tick(1);
    check("step1_rise", 32'(cpu_if.run), 32'd1);
    tick(3);
    step_i = 1'b0;
    tick(2);
    check("step1_hold", 32'(cpu_if.run), 32'd1);
    cpu_if.instr_done = 1'b1;
    tick(1);
    cpu_if.instr_done = 1'b0;
    check("step1_fall", 32'(cpu_if.run), 32'd0);
    tick(8);
    check("step1_idle", 32'(cpu_if.run), 32'd0);
    step_i = 1'b1;
    tick(7);
    check("step2_rise", 32'(cpu_if.run), 32'd1);
    tick(2);
    cpu_if.instr_done = 1'b1;
    tick(1);
    cpu_if.instr_done = 1'b0;
    check("step2_fall", 32'(cpu_if.run), 32'd0);
    step_i = 1'b0;
    tick(8);

    // Bouncing inc is rejected; a steady press counts once
    for (int i = 0; i < 3; i++) begin
      inc_i = 1'b1; tick(2);
      inc_i = 1'b0; tick(2);
    end
    check("bounce_none", 32'(cpu_if.addr), 32'd0);
    inc_i = 1'b1;
    tick(8);
    check("bounce_once", 32'(cpu_if.addr), 32'd1);
    tick(8);
    check("bounce_hold", 32'(cpu_if.addr), 32'd1);
    inc_i = 1'b0;
    tick(8);
    check("led_addr_pc", 32'(led_o), 32'hA501);
    inc_i = 1'b1; dec_i = 1'b1;
    tick(12);
    check("inc_dec_both", 32'(cpu_if.addr), 32'd1);
    inc_i = 1'b0; dec_i = 1'b0;
    tick(8);

    // Wrap in full and register views
    press(3);
    check("dec_to0", 32'(cpu_if.addr), 32'd0);
    press(3);
    check("dec_wrap", 32'(cpu_if.addr), 32'hFF);
    check("led_ff", 32'(led_o[7:0]), 32'hFF);
    sel_i = 2'd1;
    tick(2);
    check("sel1_mask", 32'(cpu_if.addr), 32'h1F);
    press(2);
    check("sel1_inc_wrap", 32'(cpu_if.addr), 32'd0);
    check("sel1_led", 32'(led_o[7:0]), 32'h00);
    press(3);
    check("sel1_dec_wrap", 32'(cpu_if.addr), 32'h1F);
    check("sel1_led31", 32'(led_o[7:0]), 32'h1F);

    // Display scanning
    sel_i = 2'd0;
    check_frame("disp_mem", 32'h1234_ABCD, 8);
    sel_i = 2'd2;
    check_frame("disp_pc", 32'h0000_00A5, 3);
    sel_i = 2'd3;
    check_frame("disp_addr", 32'h0000_001F, 3);
    sel_i = 2'd0;

    // Continuous run
    cont_i = 1'b1;
    tick(6);
    check("cont_pre", 32'(cpu_if.run), 32'd0);
    tick(1);
    check("cont_rise", 32'(cpu_if.run), 32'd1);
    tick(4);
    cont_i = 1'b0;
    tick(6);
    check("cont_hold", 32'(cpu_if.run), 32'd1);
    tick(1);
    check("cont_fall", 32'(cpu_if.run), 32'd0);
    tick(8);

`ifdef DDU_BREAKPOINT_EN
    cpu_if.bp_addr  = 32'h0000_000C;
    cpu_if.bp_valid = 1'b1;
    cpu_if.pc       = 32'h0000_000C;
    cont_i = 1'b1;
    tick(7);
    check("bp_run", 32'(cpu_if.run), 32'd1);
    cpu_if.instr_done = 1'b1;
    tick(1);
    cpu_if.instr_done = 1'b0;
    check("bp_halt", 32'(cpu_if.run), 32'd0);
    tick(1);
    check("bp_led15", 32'(led_o[15]), 32'd1);
    tick(4);
    check("bp_stay", 32'(cpu_if.run), 32'd0);
    cont_i = 1'b0;
    cpu_if.bp_valid = 1'b0;
    cpu_if.pc = 32'h0000_00A5;
    tick(10);
`endif

    // Reset in the middle of a step
    step_i = 1'b1;
    tick(7);
    check("rst_step_run", 32'(cpu_if.run), 32'd1);
    tick(1);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_run", 32'(cpu_if.run), 32'd0);
    check("rst_mid_an", 32'(an_o), 32'hFF);
    check("rst_mid_seg", 32'(seg_o), 32'h7F);
    check("rst_mid_addr", 32'(cpu_if.addr), 32'd0);
    step_i = 1'b0;
    tick(2);
    rst_ni = 1'b1;
    tick(12);
    check("rst_no_pending", 32'(cpu_if.run), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
